// File: rtl/mc_cpu_handshake.sv
`default_nettype none
// ============================================================================
// Module      : mc_cpu_handshake
// Description : Multi-cycle MIPS-subset core (IF/ID/EX/MEM/WB) with req/ack
//               instruction and data memory ports; optional performance
//               counters enabled by defining MC_CPU_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_cpu_handshake #(
    parameter int                  DATA_LEN = 32,
    parameter int                  ADDR_LEN = 32,
    parameter int                  REG_NUM  = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_LEN-1:0] dmem_addr,
    output logic [DATA_LEN-1:0] dmem_wdata,
    input  logic                dmem_ack,
    input  logic [DATA_LEN-1:0] dmem_rdata,
    output logic [ADDR_LEN-1:0] pc,
    output logic [31:0]         inst,
    output logic                retire,
    output logic                trap
`ifdef MC_CPU_PERF_CNT_EN
    ,
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         retire_cnt
`endif
);

    localparam int c_RW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    localparam logic [2:0] c_ST_IF   = 3'd0;
    localparam logic [2:0] c_ST_ID   = 3'd1;
    localparam logic [2:0] c_ST_EX   = 3'd2;
    localparam logic [2:0] c_ST_MEM  = 3'd3;
    localparam logic [2:0] c_ST_WB   = 3'd4;
    localparam logic [2:0] c_ST_TRAP = 3'd5;

    localparam logic [ADDR_LEN-1:0] c_LOW28 = ADDR_LEN'(28'hFFF_FFFF);

    logic [2:0]          r_state, w_state_nxt;
    logic [ADDR_LEN-1:0] r_pc;
    logic [31:0]         r_inst;
    logic [DATA_LEN-1:0] r_regs [REG_NUM];
    logic [DATA_LEN-1:0] r_a, r_b, r_imm, r_alu, r_mdr;

    logic [5:0]          w_op, w_fn;
    logic [c_RW-1:0]     w_rs, w_rt, w_rd, w_wb_dst;
    logic                w_is_r, w_is_addi, w_is_ori, w_is_lw, w_is_sw, w_is_beq, w_is_j;
    logic                w_legal, w_zero;
    logic [DATA_LEN-1:0] w_opb, w_alu, w_wb_data;
    logic [ADDR_LEN-1:0] w_pc4, w_br_off, w_jtgt, w_pc_nxt;

    // Decode is driven straight from the latched instruction word
    assign w_op = r_inst[31:26];
    assign w_fn = r_inst[5:0];
    assign w_rs = r_inst[21 +: c_RW];
    assign w_rt = r_inst[16 +: c_RW];
    assign w_rd = r_inst[11 +: c_RW];

    assign w_is_r    = (w_op == 6'h00) && (w_fn == 6'h20 || w_fn == 6'h22 || w_fn == 6'h24 ||
                                           w_fn == 6'h25 || w_fn == 6'h2A);
    assign w_is_addi = (w_op == 6'h08);
    assign w_is_ori  = (w_op == 6'h0D);
    assign w_is_lw   = (w_op == 6'h23);
    assign w_is_sw   = (w_op == 6'h2B);
    assign w_is_beq  = (w_op == 6'h04);
    assign w_is_j    = (w_op == 6'h02);
    assign w_legal   = w_is_r | w_is_addi | w_is_ori | w_is_lw | w_is_sw | w_is_beq | w_is_j;

    assign w_opb  = (w_is_r || w_is_beq) ? r_b : r_imm;
    assign w_zero = (r_a == r_b);

    always_comb begin
        w_alu = r_a + w_opb;
        if (w_is_ori) begin
            w_alu = r_a | r_imm;
        end else if (w_is_r) begin
            case (w_fn)
                6'h22:   w_alu = r_a - r_b;
                6'h24:   w_alu = r_a & r_b;
                6'h25:   w_alu = r_a | r_b;
                6'h2A:   w_alu = DATA_LEN'($signed(r_a) < $signed(r_b));
                default: w_alu = r_a + r_b;
            endcase
        end
    end

    assign w_pc4    = r_pc + ADDR_LEN'(4);
    assign w_br_off = ADDR_LEN'($signed(r_inst[15:0])) << 2;
    assign w_jtgt   = (w_pc4 & ~c_LOW28) | ADDR_LEN'({r_inst[25:0], 2'b00});
    assign w_pc_nxt = (w_is_beq && w_zero) ? (w_pc4 + w_br_off) :
                      w_is_j               ? w_jtgt : w_pc4;

    assign w_wb_dst  = w_is_r ? w_rd : w_rt;
    assign w_wb_data = w_is_lw ? r_mdr : r_alu;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IF;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IF:   if (imem_ack) w_state_nxt = c_ST_ID;
            c_ST_ID:   w_state_nxt = w_legal ? c_ST_EX : c_ST_TRAP;
            c_ST_EX: begin
                if (w_is_lw || w_is_sw)       w_state_nxt = c_ST_MEM;
                else if (w_is_beq || w_is_j)  w_state_nxt = c_ST_IF;
                else                          w_state_nxt = c_ST_WB;
            end
            c_ST_MEM:  if (dmem_ack) w_state_nxt = w_is_lw ? c_ST_WB : c_ST_IF;
            c_ST_WB:   w_state_nxt = c_ST_IF;
            c_ST_TRAP: w_state_nxt = c_ST_TRAP;
            default:   w_state_nxt = c_ST_IF;
        endcase
    end

    // Requests are masked by rst so they drop the instant reset is asserted
    always_comb begin
        imem_req = (r_state == c_ST_IF) && !rst;
        dmem_req = (r_state == c_ST_MEM) && !rst;
        dmem_we  = dmem_req && w_is_sw;
        trap     = (r_state == c_ST_TRAP);
        retire   = (r_state == c_ST_WB) ||
                   ((r_state == c_ST_EX) && (w_is_beq || w_is_j)) ||
                   ((r_state == c_ST_MEM) && dmem_ack && w_is_sw);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_inst <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_imm  <= '0;
            r_alu  <= '0;
            r_mdr  <= '0;
            for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
        end else begin
            if (r_state == c_ST_IF && imem_ack) r_inst <= imem_rdata;
            if (r_state == c_ST_ID) begin
                r_a   <= r_regs[w_rs];
                r_b   <= r_regs[w_rt];
                r_imm <= w_is_ori ? DATA_LEN'(r_inst[15:0]) : DATA_LEN'($signed(r_inst[15:0]));
            end
            if (r_state == c_ST_EX) r_alu <= w_alu;
            if (r_state == c_ST_MEM && dmem_ack) r_mdr <= dmem_rdata;
            if (r_state == c_ST_WB && w_wb_dst != '0) r_regs[w_wb_dst] <= w_wb_data;
            if (retire) r_pc <= w_pc_nxt;
        end
    end

    assign pc         = r_pc;
    assign inst       = r_inst;
    assign imem_addr  = r_pc;
    assign dmem_addr  = ADDR_LEN'(r_alu);
    assign dmem_wdata = r_b;

`ifdef MC_CPU_PERF_CNT_EN
    logic [31:0] r_cycle_cnt, r_retire_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (r_state != c_ST_TRAP) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (retire)               r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign cycle_cnt  = r_cycle_cnt;
    assign retire_cnt = r_retire_cnt;
`endif

endmodule
`default_nettype wire
